// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
//   Paces one single-slot command packet to the ADC core per sample period,
//   captures the matching conversion result, optionally re-centres it to
//   two's complement, and queues it in a 4-entry FIFO for the consumer.
//   Pacing misses, timeouts and FIFO drops are reported as status.
//
// Ports
//   clock_clk, reset_sink_reset        : clock, synchronous active-high reset
//   enable                             : run the sample-rate divider
//   command_*                          : command stream to the ADC core
//   response_*                         : result stream from the ADC core
//                                        (sop/eop/empty are not used)
//   sample_valid/ready/data            : 12-bit sample output, valid/ready
//   clear_status                       : pulse, clears the status outputs
//   missed_tick, timeout_flag          : sticky status flags
//   drop_count                         : saturating count of dropped results
module adc_sample_sequencer #(
  parameter int         CLK_DIV    = 6250,
  parameter logic [4:0] CHANNEL    = 5'd1,
  parameter int         TIMEOUT    = 1023,
  parameter bit         SIGNED_OUT = 1'b1
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset,
  input  logic        enable,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  input  logic        response_empty,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [11:0] sample_data,
  input  logic        clear_status,
  output logic        missed_tick,
  output logic        timeout_flag,
  output logic [15:0] drop_count
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, CMD, WAIT_RSP} state_t;

  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;
  state_t           state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic             rsp_match, capture, timeout_evt, missed_evt;
  logic             command_valid_reg;

  logic [11:0]      fifo_mem [4];
  logic [1:0]       wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [2:0]       count_reg, count_next;
  logic             fifo_full, pop, wr_en, drop_evt;
  logic [11:0]      cap_data, head_next;
  logic             sample_valid_reg;
  logic [11:0]      sample_data_reg;
  logic             missed_tick_reg, timeout_flag_reg;
  logic [15:0]      drop_count_reg;

  // Packet framing and empty are meaningless for single-slot results.
  logic unused_rsp_sideband;
  assign unused_rsp_sideband = response_startofpacket ^ response_endofpacket ^ response_empty;

  // Sample-rate divider: free-runs while enabled, parked at 0 otherwise.
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset || !enable || tick)
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_reg + 1'b1;
  end

  assign tick = enable && (div_cnt_reg == DIV_W'(CLK_DIV - 1));

  assign rsp_match  = response_valid && (response_channel == CHANNEL);
  assign missed_evt = tick && (state_reg != IDLE);

  // Sequencer FSM
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      command_valid_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      // Registered copy of "in CMD" so the command port is glitch-free.
      command_valid_reg <= (state_next == CMD);
    end
  end

  always_comb begin
    state_next  = state_reg;
    timer_next  = timer_reg;
    capture     = 1'b0;
    timeout_evt = 1'b0;
    case (state_reg)
      IDLE: begin
        if (tick)
          state_next = CMD;
      end
      CMD: begin
        // Once raised, the command is never retracted, even if enable drops.
        if (command_ready) begin
          state_next = WAIT_RSP;
          timer_next = '0;
        end
      end
      WAIT_RSP: begin
        // A match on the final timer cycle still counts as a capture.
        if (rsp_match) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (timer_reg == TMR_W'(TIMEOUT)) begin
          timeout_evt = 1'b1;
          state_next  = IDLE;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output FIFO with a registered head (sample_data/sample_valid).
  assign cap_data    = SIGNED_OUT ? (response_data ^ 12'h800) : response_data;
  assign fifo_full   = (count_reg == 3'd4);
  assign pop         = sample_valid_reg && sample_ready;
  assign wr_en       = capture && (!fifo_full || pop);
  assign drop_evt    = capture && fifo_full && !pop;
  assign rd_ptr_next = rd_ptr_reg + {1'b0, pop};
  assign count_next  = count_reg + {2'b00, wr_en} - {2'b00, pop};

  // The slot that becomes head may be the one being written this cycle
  // (FIFO empty, or draining its last entry), so forward the new data.
  always_comb begin
    head_next = fifo_mem[rd_ptr_next];
    if (wr_en && (wr_ptr_reg == rd_ptr_next))
      head_next = cap_data;
  end

  always_ff @(posedge clock_clk) begin
    if (wr_en)
      fifo_mem[wr_ptr_reg] <= cap_data;
  end

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      sample_valid_reg <= 1'b0;
      sample_data_reg  <= '0;
    end else begin
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      sample_valid_reg <= (count_next != 3'd0);
      if (count_next != 3'd0)
        sample_data_reg <= head_next;
    end
  end

  // Status: a set event in the same cycle as clear_status takes priority.
  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      missed_tick_reg  <= 1'b0;
      timeout_flag_reg <= 1'b0;
      drop_count_reg   <= '0;
    end else begin
      if (missed_evt)
        missed_tick_reg <= 1'b1;
      else if (clear_status)
        missed_tick_reg <= 1'b0;

      if (timeout_evt)
        timeout_flag_reg <= 1'b1;
      else if (clear_status)
        timeout_flag_reg <= 1'b0;

      if (drop_evt) begin
        if (clear_status)
          drop_count_reg <= 16'd1;
        else if (drop_count_reg != 16'hFFFF)
          drop_count_reg <= drop_count_reg + 1'b1;
      end else if (clear_status) begin
        drop_count_reg <= '0;
      end
    end
  end

  assign command_valid         = command_valid_reg;
  assign command_startofpacket = command_valid_reg;
  assign command_endofpacket   = command_valid_reg;
  assign command_channel       = CHANNEL;
  assign sample_valid          = sample_valid_reg;
  assign sample_data           = sample_data_reg;
  assign missed_tick           = missed_tick_reg;
  assign timeout_flag          = timeout_flag_reg;
  assign drop_count            = drop_count_reg;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
`timescale 1ns/1ps
// Bench for adc_sample_sequencer: a random ADC/consumer driver, a
// transaction-level reference model fed only by the DUT inputs, and a
// negedge monitor that compares outputs and pops the expected-sample queue.
module tb_adc_sample_sequencer;

  localparam int         CLK_DIV    = 8;
  localparam int         TIMEOUT    = 10;
  localparam logic [4:0] CH         = 5'd1;
  localparam bit         SIGNED_OUT = 1'b1;

  logic        clock_clk = 1'b0;
  logic        reset_sink_reset;
  logic        enable;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_startofpacket;
  logic        command_endofpacket;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [11:0] sample_data;
  logic        clear_status;
  logic        missed_tick;
  logic        timeout_flag;
  logic [15:0] drop_count;

  always #5 clock_clk = ~clock_clk;

  adc_sample_sequencer #(
    .CLK_DIV(CLK_DIV), .CHANNEL(CH), .TIMEOUT(TIMEOUT), .SIGNED_OUT(SIGNED_OUT)
  ) dut (
    .clock_clk(clock_clk),
    .reset_sink_reset(reset_sink_reset),
    .enable(enable),
    .command_valid(command_valid),
    .command_channel(command_channel),
    .command_startofpacket(command_startofpacket),
    .command_endofpacket(command_endofpacket),
    .command_ready(command_ready),
    .response_valid(response_valid),
    .response_startofpacket(response_valid),
    .response_endofpacket(response_valid),
    .response_empty(1'b0),
    .response_channel(response_channel),
    .response_data(response_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .sample_data(sample_data),
    .clear_status(clear_status),
    .missed_tick(missed_tick),
    .timeout_flag(timeout_flag),
    .drop_count(drop_count)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_samples = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- driver configuration ----------------
  int ready_pct = 100;
  int dly_min = 3, dly_max = 3;
  int wrong_pct = 0;
  int spur_pct = 0;
  int sink_pct = 100;
  int data_mode = 0;          // 0 fixed, 1 alternate FFF/000, 2 random
  logic [11:0] data_fix = 12'h800;
  bit alt_sel = 1'b0;

  function automatic logic [11:0] pick_data();
    if (data_mode == 0) return data_fix;
    if (data_mode == 1) begin
      alt_sel = ~alt_sel;
      return alt_sel ? 12'hFFF : 12'h000;
    end
    return 12'($urandom_range(4095, 0));
  endfunction

  task automatic step();
    @(posedge clock_clk);
    #1;
  endtask

  // ADC core and consumer emulation; inputs change 1 ns after the edge.
  initial begin
    int  rsp_cnt;
    bit  acc_pending;
    rsp_cnt = 0;
    acc_pending = 1'b0;
    command_ready = 1'b0;
    response_valid = 1'b0;
    response_channel = '0;
    response_data = '0;
    sample_ready = 1'b0;
    forever begin
      step();
      if (acc_pending)
        rsp_cnt = int'($urandom_range(dly_max, dly_min));
      response_valid = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          response_valid   = 1'b1;
          response_channel = (int'($urandom_range(99, 0)) < wrong_pct) ? 5'd3 : CH;
          response_data    = pick_data();
        end
      end else if (int'($urandom_range(99, 0)) < spur_pct) begin
        response_valid   = 1'b1;
        response_channel = 5'($urandom_range(3, 0));
        response_data    = 12'($urandom_range(4095, 0));
      end
      command_ready = (int'($urandom_range(99, 0)) < ready_pct);
      sample_ready  = (int'($urandom_range(99, 0)) < sink_pct);
      acc_pending   = command_valid && command_ready;
    end
  end

  // ---------------- reference model ----------------
  // m_phase: 0 free, 1 command outstanding, 2 waiting for the result.
  int  en_cnt = 0;
  int  m_phase = 0;
  int  wait_start = 0;
  int  m_fill = 0;
  bit  m_missed = 1'b0;
  bit  m_tmo = 1'b0;
  int  m_drops = 0;
  logic [11:0] exp_q[$];

  function automatic logic [11:0] expected_sample(input logic [11:0] raw);
    // Offset binary re-centred around mid-scale (2048).
    if (SIGNED_OUT) return 12'(int'(raw) - 2048);
    return raw;
  endfunction

  initial begin
    forever begin
      int now;
      bit tick, missed_ev, tmo_ev, cap, pop, drop_ev;
      @(posedge clock_clk);
      now = cyc;
      cyc++;
      if (reset_sink_reset) begin
        en_cnt = 0; m_phase = 0; wait_start = 0; m_fill = 0;
        m_missed = 1'b0; m_tmo = 1'b0; m_drops = 0;
        exp_q.delete();
      end else begin
        tick      = enable && (en_cnt == CLK_DIV - 1);
        en_cnt    = enable ? (en_cnt + 1) % CLK_DIV : 0;
        missed_ev = tick && (m_phase != 0);
        cap = 1'b0;
        tmo_ev = 1'b0;
        if (m_phase == 0) begin
          if (tick) m_phase = 1;
        end else if (m_phase == 1) begin
          if (command_ready) begin
            m_phase = 2;
            wait_start = now + 1;
          end
        end else begin
          if (response_valid && response_channel == CH) begin
            cap = 1'b1;
            m_phase = 0;
          end else if (now - wait_start >= TIMEOUT) begin
            tmo_ev = 1'b1;
            m_phase = 0;
          end
        end
        pop = (m_fill > 0) && sample_ready;
        drop_ev = 1'b0;
        if (cap) begin
          if (m_fill < 4 || pop) begin
            exp_q.push_back(expected_sample(response_data));
            m_fill++;
          end else begin
            drop_ev = 1'b1;
          end
        end
        if (pop) m_fill--;
        if (missed_ev) m_missed = 1'b1; else if (clear_status) m_missed = 1'b0;
        if (tmo_ev) m_tmo = 1'b1; else if (clear_status) m_tmo = 1'b0;
        if (drop_ev) m_drops = clear_status ? 1 : ((m_drops >= 65535) ? 65535 : m_drops + 1);
        else if (clear_status) m_drops = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clock_clk);
      chk("command_valid", 32'(command_valid), 32'(m_phase == 1));
      chk("command_sop", 32'(command_startofpacket), 32'(m_phase == 1));
      chk("command_eop", 32'(command_endofpacket), 32'(m_phase == 1));
      chk("command_channel", 32'(command_channel), 32'(CH));
      chk("sample_valid", 32'(sample_valid), 32'(m_fill > 0));
      chk("missed_tick", 32'(missed_tick), 32'(m_missed));
      chk("timeout_flag", 32'(timeout_flag), 32'(m_tmo));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (sample_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sample_unexpected: got data %03h want no sample (cycle %0d)", sample_data, cyc);
        end else begin
          chk("sample_data", 32'(sample_data), 32'(exp_q[0]));
          if (sample_ready === 1'b1) begin
            n_samples++;
            $display("sample %0d data %03h cycle %0d", n_samples, sample_data, cyc);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_command_valid"}, 32'(command_valid), 32'd0);
    chk({tag, "_command_sop"}, 32'(command_startofpacket), 32'd0);
    chk({tag, "_command_eop"}, 32'(command_endofpacket), 32'd0);
    chk({tag, "_command_channel"}, 32'(command_channel), 32'd1);
    chk({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
    chk({tag, "_sample_data"}, 32'(sample_data), 32'd0);
    chk({tag, "_missed_tick"}, 32'(missed_tick), 32'd0);
    chk({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
    chk({tag, "_drop_count"}, 32'(drop_count), 32'd0);
  endtask

  // ---------------- stimulus sequence ----------------
  initial begin
    int n;
    reset_sink_reset = 1'b1;
    enable = 1'b0;
    clear_status = 1'b0;
    repeat (4) step();
    reset_sink_reset = 1'b0;
    step();
    check_reset_outputs("por");

    // Mid-scale input with immediate acceptance: samples read 000.
    enable = 1'b1;
    repeat (80) step();

    // Full-scale extremes.
    data_mode = 1;
    repeat (48) step();

    // Consumer stalls for six periods, then drains.
    data_mode = 2;
    sink_pct = 0;
    repeat (48) step();
    sink_pct = 100;
    repeat (40) step();

    // ADC never answers in time.
    dly_min = 14; dly_max = 14;
    repeat (40) step();
    chk("timeout_flag_set", 32'(timeout_flag), 32'd1);
    clear_status = 1'b1;
    step();
    clear_status = 1'b0;
    dly_min = 3; dly_max = 3;
    repeat (20) step();

    // ADC core stalls the command; results on a foreign channel.
    ready_pct = 0;
    repeat (20) step();
    wrong_pct = 100;
    ready_pct = 100;
    repeat (24) step();
    wrong_pct = 0;
    repeat (24) step();

    // Randomised soak.
    for (int blk = 0; blk < 60; blk++) begin
      ready_pct = int'($urandom_range(100, 30));
      dly_min   = int'($urandom_range(6, 1));
      dly_max   = dly_min + int'($urandom_range(8, 0));
      wrong_pct = int'($urandom_range(30, 0));
      spur_pct  = int'($urandom_range(8, 0));
      sink_pct  = int'($urandom_range(100, 0));
      enable    = ($urandom_range(9, 0) != 0);
      for (int i = 0; i < 50; i++) begin
        clear_status = ($urandom_range(39, 0) == 0);
        step();
      end
      clear_status = 1'b0;
    end

    // Reset while waiting for a result; the late result must be ignored.
    enable = 1'b1; ready_pct = 100; dly_min = 8; dly_max = 8;
    wrong_pct = 0; spur_pct = 0; sink_pct = 100;
    n = 0;
    while (m_phase != 2 && n < 100) begin
      step();
      n++;
    end
    chk("reach_wait_rsp", 32'(m_phase == 2), 32'd1);
    reset_sink_reset = 1'b1;
    enable = 1'b0;
    step();
    reset_sink_reset = 1'b0;
    repeat (12) step();
    check_reset_outputs("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
